counter_updown_n: RTL and testbench

COUNTER_UPDOWN_N -- requirements
Module: counter_updown_n

---
 rtl/counter_updown_n.sv | 78 +++++++
 tb/tb_counter_updown_n.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/counter_updown_n.sv
// Up/down counter over 0..MAX_VAL with synchronous clamped load and a one-cycle wrap pulse.
// Defining COUNTER_UPDOWN_SAT_EN selects saturating mode: the count holds at either end and wrap stays 0.
module counter_updown_n #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   MAX_VAL = '1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  // Boundary steps are handled as explicit cases, so +1/-1 is only ever
  // applied strictly inside the range and cannot carry or borrow out.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = clamp_load(load_val);
    end else if (en) begin
      if (dir) begin
        if (cnt_q == MAX_VAL) begin
`ifdef COUNTER_UPDOWN_SAT_EN
          cnt_d  = MAX_VAL;
`else
          cnt_d  = ZERO;
          wrap_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == ZERO) begin
`ifdef COUNTER_UPDOWN_SAT_EN
          cnt_d  = ZERO;
`else
          cnt_d  = MAX_VAL;
          wrap_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q  <= ZERO;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt    = cnt_q;
  assign wrap   = wrap_q;
  assign at_max = (cnt_q == MAX_VAL);
  assign at_min = (cnt_q == ZERO);

endmodule

// File: tb/tb_counter_updown_n.sv
// Directed bench for counter_updown_n: a WIDTH=4/MAX_VAL=9 instance driven from a vector table,
// plus a default WIDTH=8 instance run through a full wrap; expectations follow COUNTER_UPDOWN_SAT_EN.
module tb_counter_updown_n;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  logic       en_a = 0, dir_a = 0, load_a = 0;
  logic [3:0] lv_a = '0;
  logic [3:0] cnt_a;
  logic       wrap_a, amax_a, amin_a;

  logic       en_b = 0, dir_b = 0, load_b = 0;
  logic [7:0] lv_b = '0;
  logic [7:0] cnt_b;
  logic       wrap_b, amax_b, amin_b;

  counter_updown_n #(.WIDTH(4), .MAX_VAL(4'd9)) dut_a (
    .clock(clock), .rst(rst), .en(en_a), .dir(dir_a), .load(load_a), .load_val(lv_a),
    .cnt(cnt_a), .wrap(wrap_a), .at_max(amax_a), .at_min(amin_a)
  );

  counter_updown_n dut_b (
    .clock(clock), .rst(rst), .en(en_b), .dir(dir_b), .load(load_b), .load_val(lv_b),
    .cnt(cnt_b), .wrap(wrap_b), .at_max(amax_b), .at_min(amin_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_a(input string name, input logic [3:0] c, input logic w, input logic mx, input logic mn);
    chk({name, ".cnt"}, 32'(cnt_a), 32'(c));
    chk({name, ".wrap"}, 32'(wrap_a), 32'(w));
    chk({name, ".at_max"}, 32'(amax_a), 32'(mx));
    chk({name, ".at_min"}, 32'(amin_a), 32'(mn));
  endtask

  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       dir;
    logic [3:0] cnt;
    logic       wrap;
    logic       amax;
    logic       amin;
  } vec_t;

  vec_t tbl[24];

  initial begin
    tbl[0]  = '{1'b1, 4'd3,  1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
`ifdef COUNTER_UPDOWN_SAT_EN
    tbl[4]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
`else
    tbl[4]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0};
`endif
    tbl[6]  = '{1'b1, 4'd14, 1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0};
`ifdef COUNTER_UPDOWN_SAT_EN
    tbl[7]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0};
`else
    tbl[7]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0};
`endif
    tbl[10] = '{1'b1, 4'd5,  1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 4'd0,  1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 4'd9,  1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 4'd0,  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
`ifdef COUNTER_UPDOWN_SAT_EN
    tbl[18] = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
`else
    tbl[18] = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0};
`endif
    tbl[19] = '{1'b1, 4'd7,  1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 4'd10, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0};
    tbl[22] = '{1'b1, 4'd15, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0};
    tbl[23] = '{1'b1, 4'd7,  1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0};

    // asynchronous reset at start, no clock edge needed
    #1 rst = 1'b1;
    #1;
    chk_a("reset_a", 4'd0, 1'b0, 1'b0, 1'b1);
    chk("reset_b.cnt", 32'(cnt_b), 32'd0);
    chk("reset_b.wrap", 32'(wrap_b), 32'd0);
    chk("reset_b.at_min", 32'(amin_b), 32'd1);
    @(negedge clock) rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      load_a = tbl[i].ld; lv_a = tbl[i].lv; en_a = tbl[i].en; dir_a = tbl[i].dir;
      @(posedge clock);
      #1;
      chk_a($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].wrap, tbl[i].amax, tbl[i].amin);
    end

    // reset raised between edges with cnt=7 while load/en are active
    @(negedge clock);
    load_a = 1'b1; lv_a = 4'd3; en_a = 1'b1; dir_a = 1'b1;
    #2 rst = 1'b1;
    #1 chk_a("rst_mid", 4'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clock);
    #1 chk_a("rst_held", 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    rst = 1'b0; load_a = 1'b0; en_a = 1'b1; dir_a = 1'b1;
    @(posedge clock);
    #1 chk_a("rst_release", 4'd1, 1'b0, 1'b0, 1'b0);

    // reset arriving while a wrap pulse is high clears it without a clock
    @(negedge clock);
    load_a = 1'b1; lv_a = 4'd0; en_a = 1'b0;
    @(negedge clock);
    load_a = 1'b0; en_a = 1'b1; dir_a = 1'b0;
    @(posedge clock);
`ifdef COUNTER_UPDOWN_SAT_EN
    #1 chk_a("pre_rst_wrap", 4'd0, 1'b0, 1'b0, 1'b1);
`else
    #1 chk_a("pre_rst_wrap", 4'd9, 1'b1, 1'b1, 1'b0);
`endif
    #2 rst = 1'b1;
    #1 chk_a("rst_kills_wrap", 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    rst = 1'b0; en_a = 1'b0;

    // full-range run on the default 8-bit instance
    en_b = 1'b1; dir_b = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      logic [7:0] ec;
      logic       ew;
`ifdef COUNTER_UPDOWN_SAT_EN
      ec = (k > 255) ? 8'd255 : 8'(k);
      ew = 1'b0;
`else
      ec = 8'(k % 256);
      ew = (k == 256);
`endif
      @(posedge clock);
      #1;
      chk($sformatf("run%0d.cnt", k), 32'(cnt_b), 32'(ec));
      chk($sformatf("run%0d.wrap", k), 32'(wrap_b), 32'(ew));
      chk($sformatf("run%0d.at_max", k), 32'(amax_b), 32'(ec == 8'd255));
      chk($sformatf("run%0d.at_min", k), 32'(amin_b), 32'(ec == 8'd0));
    end
    en_b = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
